// File: rtl/home_pkg.sv
// Shared definitions for the presence-monitor slice.
//   presence_state_t : presence FSM encodings (HOME/AWAY/OVERDUE; 2'b11 is illegal)
//   sched_state_t    : daily-schedule FSM state codes that feed the `home` level
//   DEF_*            : default widths/limits used by home_presence_monitor and home_hist_fifo
package home_pkg;

  localparam int unsigned DEF_CNT_W      = 8;
  localparam int unsigned DEF_DAY_W      = 8;
  localparam int unsigned DEF_LIMIT      = 3;
  localparam int unsigned DEF_HIST_DEPTH = 4;

  typedef enum logic [1:0] {
    HOME    = 2'b00,
    AWAY    = 2'b01,
    OVERDUE = 2'b10
  } presence_state_t;

  // Upstream daily schedule: one at-home state followed by three away states.
  typedef enum logic [1:0] {
    SCHED_HOME    = 2'b00,
    SCHED_COMMUTE = 2'b01,
    SCHED_WORK    = 2'b10,
    SCHED_RETURN  = 2'b11
  } sched_state_t;

  function automatic logic sched_is_home(input sched_state_t s);
    return (s == SCHED_HOME);
  endfunction

endpackage

// File: rtl/home_hist_fifo.sv
// History FIFO of completed absence lengths (used only with HOME_HISTORY_EN).
// Circular buffer with read/write pointers and an occupancy count. A push while
// full overwrites by dropping the oldest entry. A pop while empty is ignored.
//   clk, rst_ : clock, asynchronous active-low reset (FIFO empties)
//   wr        : push wr_data
//   rd        : pop head
//   rd_data   : head entry, show-ahead (valid while empty=0)
//   empty     : no entries stored
// HIST_DEPTH must be a power of 2 (pointers wrap naturally).
module home_hist_fifo
  import home_pkg::*;
#(
  parameter int unsigned CNT_W      = DEF_CNT_W,
  parameter int unsigned HIST_DEPTH = DEF_HIST_DEPTH
) (
  input  logic             clk,
  input  logic             rst_,
  input  logic             wr,
  input  logic [CNT_W-1:0] wr_data,
  input  logic             rd,
  output logic [CNT_W-1:0] rd_data,
  output logic             empty
);

  localparam int unsigned PTR_W = (HIST_DEPTH > 1) ? $clog2(HIST_DEPTH) : 1;

  logic [CNT_W-1:0] mem [HIST_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             full;
  logic             do_rd;
  logic             pop_head;

  always_comb begin
    full     = (count == (PTR_W+1)'(HIST_DEPTH));
    empty    = (count == '0);
    do_rd    = rd & ~empty;
    // Head advances on a real pop, or when a push into a full buffer evicts the oldest.
    pop_head = do_rd | (wr & full);
    rd_data  = mem[rd_ptr];
  end

  always_ff @(posedge clk) begin
    if (wr) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr)       wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_head) rd_ptr <= rd_ptr + PTR_W'(1);
      if (wr && !full && !do_rd)
        count <= count + (PTR_W+1)'(1);
      else if (do_rd && !wr)
        count <= count - (PTR_W+1)'(1);
    end
  end

endmodule

// File: rtl/home_presence_monitor.sv
// Presence monitor: consumes the schedule FSM's `home` level, emits leave/arrive
// pulses, times each absence in qualified (en=1) cycles, counts completed absences
// and flags absences longer than LIMIT. All outputs registered.
//   clk, rst_  : clock, asynchronous active-low reset
//   en         : cycle qualifier for sampling home_in
//   home_in    : home level from schedule FSM
//   leave      : 1-cycle pulse on home 1->0
//   arrive     : 1-cycle pulse on home 0->1
//   away_cnt   : running (saturating) length of the current absence, 0 while home
//   last_away  : length of the most recently completed absence
//   day_cnt    : completed absences (wrapping)
//   overdue    : current absence exceeded LIMIT
//   hist_rd / hist_data / hist_empty : absence history FIFO, present only when
//                HOME_HISTORY_EN is defined
module home_presence_monitor
  import home_pkg::*;
#(
  parameter int unsigned CNT_W      = DEF_CNT_W,
  parameter int unsigned DAY_W      = DEF_DAY_W,
  parameter int unsigned LIMIT      = DEF_LIMIT,
  parameter int unsigned HIST_DEPTH = DEF_HIST_DEPTH
) (
  input  logic             clk,
  input  logic             rst_,
  input  logic             en,
  input  logic             home_in,
  output logic             leave,
  output logic             arrive,
  output logic [CNT_W-1:0] away_cnt,
  output logic [CNT_W-1:0] last_away,
  output logic [DAY_W-1:0] day_cnt,
  output logic             overdue
`ifdef HOME_HISTORY_EN
  ,
  input  logic             hist_rd,
  output logic [CNT_W-1:0] hist_data,
  output logic             hist_empty
`endif
);

  presence_state_t  state;
  logic             home_q;
  logic             fall;
  logic             rise;
  logic [CNT_W-1:0] away_inc;
  logic             over_limit;

  always_comb begin
    fall       = home_q & ~home_in;
    rise       = ~home_q & home_in;
    away_inc   = (away_cnt == '1) ? away_cnt : away_cnt + CNT_W'(1);
    // Compared before saturation, in a width that cannot overflow.
    over_limit = (32'(away_cnt) + 32'd1) > 32'(LIMIT);
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state     <= HOME;
      home_q    <= 1'b1;
      leave     <= 1'b0;
      arrive    <= 1'b0;
      away_cnt  <= '0;
      last_away <= '0;
      day_cnt   <= '0;
      overdue   <= 1'b0;
    end else begin
      leave  <= 1'b0;
      arrive <= 1'b0;
      if (!(state inside {HOME, AWAY, OVERDUE})) begin
        state <= HOME;
      end else if (en) begin
        home_q <= home_in;
        leave  <= fall;
        arrive <= rise;
        case (state)
          HOME: begin
            if (fall) begin
              state    <= AWAY;
              away_cnt <= CNT_W'(1);
            end else begin
              away_cnt <= '0;
            end
          end
          default: begin  // AWAY, OVERDUE
            if (rise) begin
              state     <= HOME;
              last_away <= away_cnt;
              day_cnt   <= day_cnt + DAY_W'(1);
              away_cnt  <= '0;
              overdue   <= 1'b0;
            end else begin
              away_cnt <= away_inc;
              if (over_limit) begin
                state   <= OVERDUE;
                overdue <= 1'b1;
              end
            end
          end
        endcase
      end
    end
  end

`ifdef HOME_HISTORY_EN
  logic hist_push;

  // Push on the same edge that loads last_away, with the value it receives.
  always_comb hist_push = en & rise & ((state == AWAY) | (state == OVERDUE));

  home_hist_fifo #(
    .CNT_W      (CNT_W),
    .HIST_DEPTH (HIST_DEPTH)
  ) u_hist (
    .clk     (clk),
    .rst_    (rst_),
    .wr      (hist_push),
    .wr_data (away_cnt),
    .rd      (hist_rd),
    .rd_data (hist_data),
    .empty   (hist_empty)
  );
`endif

endmodule

// File: tb/tb_home_presence_monitor.sv
// Bench for home_presence_monitor: default-parameter instance plus a CNT_W=3
// instance sharing the same stimulus. A presence model tracks absence length as
// an unbounded integer; outputs are compared every negedge. History checks are
// compiled when HOME_HISTORY_EN is defined.
module tb_home_presence_monitor;

  logic       clk = 1'b0;
  logic       rst_;
  logic       en;
  logic       home_in;
  logic       leave, arrive, overdue;
  logic [7:0] away_cnt, last_away, day_cnt;
  logic       c3_leave, c3_arrive, c3_overdue;
  logic [2:0] c3_away_cnt, c3_last_away;
  logic [7:0] c3_day_cnt;
`ifdef HOME_HISTORY_EN
  logic       hist_rd;
  logic [7:0] hist_data;
  logic       hist_empty;
  logic [2:0] c3_hist_data;
  logic       c3_hist_empty;
`endif

  always #5 clk = ~clk;

  home_presence_monitor dut (
    .clk(clk), .rst_(rst_), .en(en), .home_in(home_in),
    .leave(leave), .arrive(arrive), .away_cnt(away_cnt), .last_away(last_away),
    .day_cnt(day_cnt), .overdue(overdue)
`ifdef HOME_HISTORY_EN
    , .hist_rd(hist_rd), .hist_data(hist_data), .hist_empty(hist_empty)
`endif
  );

  home_presence_monitor #(.CNT_W(3)) dut3 (
    .clk(clk), .rst_(rst_), .en(en), .home_in(home_in),
    .leave(c3_leave), .arrive(c3_arrive), .away_cnt(c3_away_cnt), .last_away(c3_last_away),
    .day_cnt(c3_day_cnt), .overdue(c3_overdue)
`ifdef HOME_HISTORY_EN
    , .hist_rd(1'b0), .hist_data(c3_hist_data), .hist_empty(c3_hist_empty)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;
  int leave_seen = 0, arrive_seen = 0, overdue_seen = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  // Presence model: absence length counted in qualified samples, no saturation.
  int m_away = 0, m_last = 0, m_days = 0;
  bit m_home = 1'b1, m_leave = 1'b0, m_arrive = 1'b0;
  int m_hist[$];

  always @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      m_away = 0; m_last = 0; m_days = 0;
      m_home = 1'b1; m_leave = 1'b0; m_arrive = 1'b0;
      m_hist.delete();
    end else begin
`ifdef HOME_HISTORY_EN
      if (hist_rd && m_hist.size() > 0) void'(m_hist.pop_front());
`endif
      m_leave = 1'b0; m_arrive = 1'b0;
      if (en) begin
        if (m_home && !home_in) begin
          m_leave = 1'b1; m_away = 1;
        end else if (!m_home && home_in) begin
          m_arrive = 1'b1; m_last = m_away; m_days = (m_days + 1) % 256; m_away = 0;
          m_hist.push_back(sat(m_last, 255));
          if (m_hist.size() > 4) void'(m_hist.pop_front());
        end else if (!m_home) begin
          m_away++;
        end
        m_home = home_in;
      end
    end
  end

  always @(negedge clk) begin
    chk("leave",     leave,     m_leave);
    chk("arrive",    arrive,    m_arrive);
    chk("away_cnt",  away_cnt,  sat(m_away, 255));
    chk("last_away", last_away, sat(m_last, 255));
    chk("day_cnt",   day_cnt,   m_days);
    chk("overdue",   overdue,   m_away > 3);
    chk("c3_leave",     c3_leave,     m_leave);
    chk("c3_arrive",    c3_arrive,    m_arrive);
    chk("c3_away_cnt",  c3_away_cnt,  sat(m_away, 7));
    chk("c3_last_away", c3_last_away, sat(m_last, 7));
    chk("c3_day_cnt",   c3_day_cnt,   m_days);
    chk("c3_overdue",   c3_overdue,   m_away > 3);
`ifdef HOME_HISTORY_EN
    chk("hist_empty", hist_empty, m_hist.size() == 0);
    if (m_hist.size() > 0) chk("hist_data", hist_data, m_hist[0]);
`endif
    if (leave === 1'b1)   leave_seen++;
    if (arrive === 1'b1)  arrive_seen++;
    if (overdue === 1'b1) overdue_seen++;
  end

  task automatic step(input bit e, input bit h);
    en = e; home_in = h;
    @(posedge clk); #1;
  endtask

  task automatic clear_seen();
    leave_seen = 0; arrive_seen = 0; overdue_seen = 0;
  endtask

  initial begin
    rst_ = 1'b0; en = 1'b0; home_in = 1'b1;
`ifdef HOME_HISTORY_EN
    hist_rd = 1'b0;
`endif
    #12 rst_ = 1'b1;
    @(posedge clk); #1;

    // 1: idle at home
    chk("rst_away_cnt", away_cnt, 0);
    chk("rst_day_cnt",  day_cnt,  0);
    for (int i = 0; i < 10; i++) step(1, 1);
    step(1, 1);
    chk("idle_leaves",  leave_seen, 0);
    chk("idle_arrives", arrive_seen, 0);
    chk("idle_last",    last_away, 0);
    chk("idle_overdue", overdue_seen, 0);

    // 2: three days of the 1,0,0,0 cadence
    clear_seen();
    for (int d = 0; d < 3; d++) begin
      step(1, 0); step(1, 0); step(1, 0); step(1, 1);
    end
    step(1, 1);
    chk("cad_leaves",  leave_seen, 3);
    chk("cad_arrives", arrive_seen, 3);
    chk("cad_last",    last_away, 3);
    chk("cad_days",    day_cnt, 3);
    chk("cad_overdue", overdue_seen, 0);

    // 3: six cycles away crosses LIMIT
    for (int i = 1; i <= 6; i++) begin
      step(1, 0);
      chk("ovd_away_cnt", away_cnt, i);
      chk("ovd_flag", overdue, (i > 3) ? 1 : 0);
    end
    step(1, 1);
    chk("ovd_clear", overdue, 0);
    chk("ovd_last",  last_away, 6);
    chk("ovd_days",  day_cnt, 4);
    step(1, 1);

    // 4a: en gaps during a 3-sample absence
    clear_seen();
    step(1, 0); step(0, 0); step(1, 0); step(0, 0); step(1, 0); step(0, 1); step(1, 1); step(1, 1);
    chk("en_last",    last_away, 3);
    chk("en_days",    day_cnt, 5);
    chk("en_leaves",  leave_seen, 1);
    chk("en_arrives", arrive_seen, 1);

    // 4b: 10-cycle absence, 3-bit counter saturates
    for (int i = 0; i < 10; i++) step(1, 0);
    chk("sat3_away", c3_away_cnt, 7);
    chk("sat8_away", away_cnt, 10);
    step(1, 1);
    chk("sat3_last", c3_last_away, 7);
    chk("sat8_last", last_away, 10);

    // 8-bit saturation, then day_cnt wrap 255 -> 0
    for (int i = 0; i < 260; i++) step(1, 0);
    chk("sat_away255", away_cnt, 255);
    step(1, 1);
    chk("sat_last255", last_away, 255);
    chk("sat_days", day_cnt, 7);
    for (int i = 0; i < 248; i++) begin step(1, 0); step(1, 1); end
    chk("wrap_255", day_cnt, 255);
    step(1, 0); step(1, 1);
    chk("wrap_0", day_cnt, 0);
    step(1, 1);

    // 5: reset mid-absence
    step(1, 0); step(1, 0);
    chk("pre_rst_away", away_cnt, 2);
    #2 rst_ = 1'b0;
    #1;
    chk("rst_mid_away", away_cnt, 0);
    chk("rst_mid_last", last_away, 0);
    chk("rst_mid_days", day_cnt, 0);
    @(posedge clk); #1 rst_ = 1'b1;
    step(1, 0);
    chk("post_rst_leave", leave, 1);
    step(1, 1); step(1, 1);

`ifdef HOME_HISTORY_EN
    // 6: history FIFO overwrite and pops
    rst_ = 1'b0; #2 rst_ = 1'b1;
    @(posedge clk); #1;
    for (int len = 1; len <= 5; len++) begin
      for (int i = 0; i < len; i++) step(1, 0);
      step(1, 1);
    end
    step(1, 1);
    for (int k = 0; k < 4; k++) begin
      chk("hist_nonempty", hist_empty, 0);
      chk("hist_pop", hist_data, k + 2);
      hist_rd = 1'b1; step(1, 1); hist_rd = 1'b0;
    end
    chk("hist_drained", hist_empty, 1);
    hist_rd = 1'b1; step(1, 1); hist_rd = 1'b0;
    chk("hist_rd_empty", hist_empty, 1);
    chk("hist_days", day_cnt, 5);
`endif

    step(1, 1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
